fixed_accumulator: RTL and testbench

Streaming saturating accumulator in the fixed-point domain, sitting between `float2fixed` (upstream) and `fixed2float` (downstream) in the fp16 arithmetic datapath. It sums a burst of 43-bit two's-complement fixed values (a dot-product or neuron partial-sum stream, delimited by `in_last`) into a wide internal register with guard bits. It emits one saturated 43-bit result per burst over a valid/ready handshake. Saturation matches the two-operand adder path: clamp to `{1'b0, 42'h3ffffffffff}` / `{1'b1, 42'h0}`.

---
 rtl/fixed_accumulator.sv | 140 ++++++++++++++
 tb/tb_fixed_accumulator.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_accumulator.sv
// Streaming saturating accumulator for 43-bit fixed-point bursts. Sums into a
// guard-extended register and emits one clamped result per burst over valid/ready.
module fixed_accumulator #(
  parameter int WIDTH = 43,
  parameter int GUARD = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sat,
  output logic [CNT_W-1:0] out_count
);

  localparam int AW = WIDTH + GUARD;

  localparam logic signed [AW-1:0] WMAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] WMIN = {1'b1, {(AW-1){1'b0}}};
  localparam logic signed [AW-1:0] NMAX = {{(GUARD+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] NMIN = {{(GUARD+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic {ST_ACC, ST_OUT} state_t;

  state_t                 state_q, state_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic                   first_q, first_d;
  logic                   ovf_q, ovf_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]       out_data_q, out_data_d;
  logic                   out_sat_q, out_sat_d;
  logic [CNT_W-1:0]       out_count_q, out_count_d;

  logic signed [AW-1:0]   sext, sum, acc_upd;
  logic                   wide_ovf, ovf_upd;
  logic [CNT_W-1:0]       cnt_upd;

  function automatic logic is_clamped(input logic signed [AW-1:0] v);
    return (v > NMAX) || (v < NMIN);
  endfunction

  function automatic logic [WIDTH-1:0] sat_narrow(input logic signed [AW-1:0] v);
    if (v > NMAX)      return {1'b0, {(WIDTH-1){1'b1}}};
    else if (v < NMIN) return {1'b1, {(WIDTH-1){1'b0}}};
    else               return v[WIDTH-1:0];
  endfunction

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_OUT);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_count = out_count_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    first_d     = first_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_count_d = out_count_q;

    sext     = {{GUARD{in_data[WIDTH-1]}}, in_data};
    sum      = acc_q + sext;
    wide_ovf = (acc_q[AW-1] == sext[AW-1]) && (sum[AW-1] != acc_q[AW-1]);

    // Once the wide sum has overflowed, acc stays pinned at the clamp value.
    acc_upd = acc_q;
    ovf_upd = ovf_q;
    if (first_q) begin
      acc_upd = sext;
    end else if (!ovf_q) begin
      if (wide_ovf) begin
        acc_upd = sext[AW-1] ? WMIN : WMAX;
        ovf_upd = 1'b1;
      end else begin
        acc_upd = sum;
      end
    end
    cnt_upd = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    case (state_q)
      ST_ACC: begin
        if (in_valid) begin
          acc_d   = acc_upd;
          first_d = 1'b0;
          ovf_d   = ovf_upd;
          cnt_d   = cnt_upd;
          if (in_last) begin
            out_data_d  = sat_narrow(acc_upd);
            out_sat_d   = is_clamped(acc_upd) | ovf_upd;
            out_count_d = cnt_upd;
            state_d     = ST_OUT;
          end
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_ACC;
          first_d = 1'b1;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  // Accumulator datapath: validity is carried by first_q, so no reset needed.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_ACC;
      first_q     <= 1'b1;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      first_q     <= first_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_count_q <= out_count_d;
    end
  end

endmodule

// File: tb/tb_fixed_accumulator.sv
// Self-checking bench for fixed_accumulator: vector table, hand-written corner
// sequences, and randomized bursts against a plain-arithmetic reference model.
module tb_fixed_accumulator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [42:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [42:0] out_data;
  logic        out_sat;
  logic [15:0] out_count;

  always #5 clk = ~clk;

  fixed_accumulator #(.WIDTH(43), .GUARD(8), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .out_count(out_count)
  );

  int total = 0;
  int bad   = 0;
  logic [42:0] bq[$];

  localparam logic [42:0] PMAX = 43'h3ffffffffff;
  localparam logic [42:0] NMIN = 43'h40000000000;

  typedef struct {
    string       name;
    int          n;
    logic [42:0] d0, d1, d2;
    logic [42:0] ed;
    logic        es;
    int          ec;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact integer sum, pinned at the 51-bit limits once exceeded.
  task automatic model(output logic [42:0] d, output logic s, output int c);
    longint acc  = 0;
    bit     ovf  = 0;
    longint wmax = (64'sd1 <<< 50) - 1;
    longint wmin = -(64'sd1 <<< 50);
    longint nmax = (64'sd1 <<< 42) - 1;
    longint nmin = -(64'sd1 <<< 42);
    foreach (bq[i]) begin
      if (!ovf) begin
        acc = acc + longint'($signed(bq[i]));
        if (acc > wmax) begin acc = wmax; ovf = 1; end
        else if (acc < wmin) begin acc = wmin; ovf = 1; end
      end
    end
    c = (bq.size() > 65535) ? 65535 : bq.size();
    if (acc > nmax)      begin d = PMAX; s = 1'b1; end
    else if (acc < nmin) begin d = NMIN; s = 1'b1; end
    else                 begin d = 43'(acc); s = ovf; end
  endtask

  task automatic send_beats(input bit with_last, input bit gaps);
    foreach (bq[i]) begin
      int w = 0;
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_data  = 43'({$urandom(), $urandom()});
        in_last  = 1'b1;
        tick();
      end
      while (!in_ready && w < 50) begin tick(); w++; end
      if (w >= 50) chk("in_ready_timeout", 64'(in_ready), 64'(1));
      in_valid = 1'b1;
      in_data  = bq[i];
      in_last  = with_last && (i == bq.size() - 1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_burst(input string name, input logic [42:0] ed, input logic es,
                           input int ec, input int hold, input bit gaps);
    send_beats(1'b1, gaps);
    chk({name, "_valid"}, 64'(out_valid), 64'(1));
    chk({name, "_data"},  64'(out_data),  64'(ed));
    chk({name, "_sat"},   64'(out_sat),   64'(es));
    chk({name, "_count"}, 64'(out_count), 64'(ec));
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({name, "_hold_data"}, 64'(out_data), 64'(ed));
      chk({name, "_hold_rdy"},  64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, "_exit_valid"}, 64'(out_valid), 64'(0));
    chk({name, "_exit_ready"}, 64'(in_ready),  64'(1));
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_valid"}, 64'(out_valid), 64'(0));
    chk({name, "_ready"}, 64'(in_ready),  64'(1));
    chk({name, "_data"},  64'(out_data),  64'(0));
    chk({name, "_sat"},   64'(out_sat),   64'(0));
    chk({name, "_count"}, 64'(out_count), 64'(0));
  endtask

  initial begin
    logic [42:0] ed;
    logic        es;
    int          ec;

    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk_reset_state("reset");
    reset_n = 1'b1;

    tbl[0] = '{"single",  1, 43'h00000001000, 43'h0, 43'h0, 43'h00000001000, 1'b0, 1};
    tbl[1] = '{"mixed",   3, 43'h5, 43'h7fffffffffd, 43'ha, 43'h0000000000c, 1'b0, 3};
    tbl[2] = '{"sat_pos", 2, PMAX, 43'h1, 43'h0, PMAX, 1'b1, 2};
    tbl[3] = '{"sat_neg", 2, NMIN, 43'h7ffffffffff, 43'h0, NMIN, 1'b1, 2};
    tbl[4] = '{"min_one", 1, NMIN, 43'h0, 43'h0, NMIN, 1'b0, 1};
    tbl[5] = '{"zero",    2, 43'h7ffffffffff, 43'h1, 43'h0, 43'h0, 1'b0, 2};

    for (int k = 0; k < 6; k++) begin
      bq.delete();
      bq.push_back(tbl[k].d0);
      if (tbl[k].n > 1) bq.push_back(tbl[k].d1);
      if (tbl[k].n > 2) bq.push_back(tbl[k].d2);
      run_burst(tbl[k].name, tbl[k].ed, tbl[k].es, tbl[k].ec, k % 2, 1'b0);
    end

    // Guard bits absorb an intermediate excursion past the output range.
    bq.delete();
    for (int i = 0; i < 256; i++) bq.push_back(PMAX);
    for (int i = 0; i < 256; i++) bq.push_back(NMIN);
    run_burst("guard", 43'h7ffffffff00, 1'b0, 512, 0, 1'b0);

    bq.delete();
    for (int i = 0; i < 300; i++) bq.push_back(PMAX);
    run_burst("big300", PMAX, 1'b1, 300, 0, 1'b0);

    bq.delete();
    for (int i = 0; i < 1100; i++) bq.push_back(PMAX);
    bq.push_back(NMIN);
    run_burst("wovf_pos", PMAX, 1'b1, 1101, 0, 1'b0);

    bq.delete();
    for (int i = 0; i < 1100; i++) bq.push_back(NMIN);
    for (int i = 0; i < 5; i++) bq.push_back(PMAX);
    run_burst("wovf_neg", NMIN, 1'b1, 1105, 0, 1'b0);

    bq.delete(); bq.push_back(43'h5);
    run_burst("post_ovf", 43'h5, 1'b0, 1, 0, 1'b0);

    // Backpressure with junk on the input
    bq.delete(); bq.push_back(43'd100); bq.push_back(43'd23);
    send_beats(1'b1, 1'b0);
    out_ready = 1'b0;
    for (int h = 0; h < 5; h++) begin
      in_valid = 1'b1;
      in_data  = 43'({$urandom(), $urandom()});
      in_last  = 1'($urandom_range(0, 1));
      tick();
      chk("bp_data",  64'(out_data),  64'(123));
      chk("bp_ready", 64'(in_ready),  64'(0));
      chk("bp_valid", 64'(out_valid), 64'(1));
      chk("bp_count", 64'(out_count), 64'(2));
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    bq.delete(); bq.push_back(43'h3);
    run_burst("bp_next", 43'h3, 1'b0, 1, 0, 1'b0);

    // Reset mid-burst
    bq.delete(); bq.push_back(43'd7); bq.push_back(43'd7);
    send_beats(1'b0, 1'b0);
    reset_n = 1'b0;
    tick();
    chk_reset_state("rst_mid");
    reset_n = 1'b1;
    bq.delete(); bq.push_back(43'd1);
    run_burst("rst_resume", 43'd1, 1'b0, 1, 0, 1'b0);

    // Reset while holding a result
    bq.delete(); bq.push_back(43'd9); bq.push_back(PMAX);
    send_beats(1'b1, 1'b0);
    chk("rst_out_pre", 64'(out_valid), 64'(1));
    reset_n = 1'b0;
    tick();
    chk_reset_state("rst_out");
    reset_n = 1'b1;

    for (int r = 0; r < 40; r++) begin
      int len = $urandom_range(1, 8);
      bq.delete();
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 3))
          0: bq.push_back(43'({$urandom(), $urandom()}));
          1: bq.push_back(PMAX - 43'($urandom_range(0, 1000)));
          2: bq.push_back(NMIN + 43'($urandom_range(0, 1000)));
          default: bq.push_back(43'($signed($urandom_range(0, 2000)) - 1000));
        endcase
      end
      model(ed, es, ec);
      run_burst("rand", ed, es, ec, $urandom_range(0, 3), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
